// File: rtl/led_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_driver_pkg                                                             |
// | Shared widths, arbiter state/owner encodings and the arbitration rule.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package led_driver_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    LOCKED = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_t;

  // A has fixed priority unless B has been starved long enough.
  function automatic owner_t pick_winner(input logic a, input logic b, input logic starved);
    if (a && b) return starved ? OWN_B : OWN_A;
    else if (a) return OWN_A;
    else if (b) return OWN_B;
    else        return OWN_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_wait_counter                                                           |
// | Saturating count of cycles port B has waited; sat flags starvation.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_wait_counter #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  C_MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_cnt <= '0;
    else if (clr)                         r_cnt <= '0;
    else if (inc && (r_cnt != C_MAX_CNT)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign sat = (r_cnt == C_MAX_CNT);

endmodule
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_bus_arbiter                                                            |
// | Two-master arbiter serialising single-register accesses onto a strobe bus. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_bus_arbiter
  import led_driver_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_w_en,
  output logic              reg_r_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [1:0]        owner
);

  arb_state_t        r_state;
  owner_t            r_owner;
  owner_t            w_winner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_w_en;
  logic              r_r_en;
  logic              r_a_done;
  logic              r_b_done;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              w_sat;
  logic              w_take_b;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_winner    = pick_winner(a_req, b_req, w_sat);
  assign w_take_b    = (r_state == IDLE) && (w_winner == OWN_B);
  assign w_sel_we    = w_take_b ? b_we    : a_we;
  assign w_sel_addr  = w_take_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_take_b ? b_wdata : a_wdata;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (b_req && (r_owner != OWN_B)),
    .clr     (w_take_b),
    .sat     (w_sat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_owner   <= OWN_NONE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_w_en    <= 1'b0;
      r_r_en    <= 1'b0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_w_en   <= 1'b0;
      r_r_en   <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_winner != OWN_NONE) begin
            r_state <= ACCESS;
            r_owner <= w_winner;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_w_en  <= w_sel_we;
            r_r_en  <= !w_sel_we;
          end
        end
        ACCESS: begin
          r_state  <= RESP;
          r_a_done <= (r_owner == OWN_A);
          r_b_done <= (r_owner == OWN_B);
        end
        RESP: begin
          if (!r_we) begin
            if (r_owner == OWN_A) r_a_rdata <= reg_rdata;
            else                  r_b_rdata <= reg_rdata;
          end
          if ((r_owner == OWN_A) && a_lock) begin
            r_state <= LOCKED;
          end else begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
          end
        end
        LOCKED: begin
          // Locked bursts skip arbitration entirely; B is not considered here.
          if (a_req) begin
            r_state <= ACCESS;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_w_en  <= w_sel_we;
            r_r_en  <= !w_sel_we;
          end else if (!a_lock) begin
            r_state <= IDLE;
            r_owner <= OWN_NONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data arrives in the done cycle, so it bypasses the holding register then.
  assign a_rdata   = (r_a_done && !r_we) ? reg_rdata : r_a_rdata;
  assign b_rdata   = (r_b_done && !r_we) ? reg_rdata : r_b_rdata;
  assign a_done    = r_a_done;
  assign b_done    = r_b_done;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_w_en  = r_w_en;
  assign reg_r_en  = r_r_en;
  assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_bus_arbiter                                                         |
// | Directed and random transactions against a transaction-level model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reg_bus_arbiter;
  import led_driver_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int NREG     = 1 << ADDR_W;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              a_req, a_we, a_lock, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_done, b_done;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_w_en, reg_r_en;
  logic [DATA_W-1:0] reg_rdata;
  logic [1:0]        owner;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] slave_mem [NREG];
  logic [DATA_W-1:0] model     [NREG];
  logic [DATA_W-1:0] exp_a_rd, exp_b_rd;
  txn_t              qa[$], qb[$];

  reg_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_w_en(reg_w_en), .reg_r_en(reg_r_en),
    .reg_rdata(reg_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int k);
    return DATA_W'(8'h4B + 17 * k);
  endfunction

  // Register file on the bus: one-cycle read latency.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) slave_mem[k] <= init_val(k);
      reg_rdata <= '0;
    end else begin
      if (reg_w_en) slave_mem[reg_addr] <= reg_wdata;
      if (reg_r_en) reg_rdata <= slave_mem[reg_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) model[k] = init_val(k);
    exp_a_rd = '0;
    exp_b_rd = '0;
  endtask

  function automatic txn_t mk(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREG - 1)), DATA_W'($urandom));
  endfunction

  // Serves queued requests (qa: A, qb: at most one B) and checks every cycle.
  // Service order: one slot per 3 cycles; B beats A once it has waited MAX_WAIT.
  task automatic run_sched(input string name);
    bit                sl_b[$];
    txn_t              sl_t[$];
    logic [DATA_W-1:0] sl_rd[$];
    int                ia, ib, n, waited;
    bit                take_b;
    txn_t              t;
    logic [DATA_W-1:0] rd;
    logic [1:0]        e_en, e_done, e_own;
    ia = 0; ib = 0;
    while (ia < qa.size() || ib < qb.size()) begin
      waited = 3 * sl_b.size();
      if (ia >= qa.size())      take_b = 1'b1;
      else if (ib >= qb.size()) take_b = 1'b0;
      else                      take_b = (waited >= MAX_WAIT);
      if (take_b) begin t = qb[ib]; ib++; end
      else        begin t = qa[ia]; ia++; end
      if (t.we) begin
        model[t.addr] = t.wdata;
        rd = take_b ? exp_b_rd : exp_a_rd;
      end else begin
        rd = model[t.addr];
      end
      if (take_b) exp_b_rd = rd; else exp_a_rd = rd;
      sl_b.push_back(take_b); sl_t.push_back(t); sl_rd.push_back(rd);
    end
    n  = sl_b.size();
    ia = 0; ib = 0;
    a_req = (qa.size() > 0);
    if (a_req) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata; end
    b_req = (qb.size() > 0);
    if (b_req) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata; end
    for (int c = 1; c <= 3 * n + 1; c++) begin
      tick();
      e_en = 2'b00; e_done = 2'b00; e_own = 2'b00;
      for (int s = 0; s < n; s++) begin
        if (c == 3 * s + 1) begin
          e_en = sl_t[s].we ? 2'b10 : 2'b01;
          check({name, ":reg_addr"}, 32'(reg_addr), 32'(sl_t[s].addr));
          if (sl_t[s].we) check({name, ":reg_wdata"}, 32'(reg_wdata), 32'(sl_t[s].wdata));
        end
        if (c == 3 * s + 2) begin
          e_done = sl_b[s] ? 2'b01 : 2'b10;
          if (sl_b[s]) check({name, ":b_rdata"}, 32'(b_rdata), 32'(sl_rd[s]));
          else         check({name, ":a_rdata"}, 32'(a_rdata), 32'(sl_rd[s]));
        end
        if (c == 3 * s + 1 || c == 3 * s + 2) e_own = sl_b[s] ? 2'b10 : 2'b01;
      end
      check({name, ":strobes"}, 32'({reg_w_en, reg_r_en}), 32'(e_en));
      check({name, ":dones"},   32'({a_done, b_done}),     32'(e_done));
      check({name, ":owner"},   32'(owner),                32'(e_own));
      if (a_done) begin
        ia++;
        if (ia < qa.size()) begin a_we = qa[ia].we; a_addr = qa[ia].addr; a_wdata = qa[ia].wdata; end
        else a_req = 1'b0;
      end
      if (b_done) begin
        ib++;
        if (ib < qb.size()) begin b_we = qb[ib].we; b_addr = qb[ib].addr; b_wdata = qb[ib].wdata; end
        else b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check({name, ":a_rdata_hold"}, 32'(a_rdata), 32'(exp_a_rd));
    check({name, ":b_rdata_hold"}, 32'(b_rdata), 32'(exp_b_rd));
    qa.delete(); qb.delete();
    repeat (2) tick();
  endtask

  initial begin : main
    logic [DATA_W-1:0] d [3];
    logic [1:0]        e_en, e_done, e_own;
    int                ka, mode;

    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst:strobes", 32'({reg_w_en, reg_r_en}), 32'(2'b00));
    check("rst:dones",   32'({a_done, b_done}),     32'(2'b00));
    check("rst:owner",   32'(owner),                32'(2'b00));
    check("rst:a_rdata", 32'(a_rdata),              32'(0));
    check("rst:b_rdata", 32'(b_rdata),              32'(0));
    check("rst:addr",    32'(reg_addr),             32'(0));
    check("rst:wdata",   32'(reg_wdata),            32'(0));
    reset_n = 1'b1;
    tick();

    qa.push_back(mk(1'b1, 3'd3, 8'hA5));
    run_sched("t1_a_write");

    qb.push_back(mk(1'b0, 3'd1, 8'h00));
    run_sched("t2_b_read");
    check("t2:b_rdata_5c", 32'(b_rdata), 32'(8'h5C));

    qa.push_back(mk(1'b1, 3'd6, 8'h77));
    qb.push_back(mk(1'b0, 3'd6, 8'h00));
    run_sched("t3_both");

    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode != 1) qa.push_back(rand_txn());
      if (mode != 0) qb.push_back(rand_txn());
      run_sched("rnd");
    end

    for (int k = 0; k < 3; k++) qa.push_back(mk(1'b1, 3'd0, DATA_W'(8'h90 + k)));
    qb.push_back(mk(1'b0, 3'd0, 8'h00));
    run_sched("t4_starve");
    check("t4:wait_cnt", 32'(u_dut.u_wait_counter.r_cnt), 32'(0));

    // Locked burst: writes 2..4, B waits until lock is released at cycle 11.
    for (int k = 0; k < 3; k++) begin
      d[k] = DATA_W'($urandom);
      model[2 + k] = d[k];
    end
    exp_b_rd = model[3];
    ka = 0;
    a_lock = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_wdata = d[0];
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd3; b_wdata = '0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      e_en = 2'b00; e_done = 2'b00; e_own = 2'b00;
      for (int k = 0; k < 3; k++) begin
        if (c == 1 + 3 * k) begin
          e_en = 2'b10;
          check("t5:reg_addr",  32'(reg_addr),  32'(2 + k));
          check("t5:reg_wdata", 32'(reg_wdata), 32'(d[k]));
        end
        if (c == 2 + 3 * k) e_done = 2'b10;
      end
      if (c == 13) e_en = 2'b01;
      if (c == 14) begin
        e_done = 2'b01;
        check("t5:b_rdata", 32'(b_rdata), 32'(exp_b_rd));
      end
      if (c <= 11) e_own = 2'b01;
      else if (c == 13 || c == 14) e_own = 2'b10;
      check("t5:strobes", 32'({reg_w_en, reg_r_en}), 32'(e_en));
      check("t5:dones",   32'({a_done, b_done}),     32'(e_done));
      check("t5:owner",   32'(owner),                32'(e_own));
      if (a_done) begin
        ka++;
        if (ka < 3) begin a_addr = ADDR_W'(2 + ka); a_wdata = d[ka]; end
        else a_req = 1'b0;
      end
      if (c == 11) a_lock = 1'b0;
      if (b_done) b_req = 1'b0;
    end
    repeat (2) tick();

    // Asynchronous reset in the middle of an access aborts it without a done.
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 8'h3C;
    tick();
    check("t6:strobe_pre", 32'({reg_w_en, reg_r_en}), 32'(2'b10));
    reset_n = 1'b0;
    #1;
    check("t6:strobes", 32'({reg_w_en, reg_r_en}), 32'(2'b00));
    check("t6:dones",   32'({a_done, b_done}),     32'(2'b00));
    check("t6:owner",   32'(owner),                32'(2'b00));
    a_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    qb.push_back(mk(1'b0, 3'd5, 8'h00));
    run_sched("t6_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
